// File: rtl/hazard_pkg.sv
// Shared constants for the hazard unit: forwarding mux
// selects and the hard-wired zero register index.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/mc_slot.sv
// One in-flight multi-cycle op: holds its destination
// and counts its latency down to a single ready cycle.
module mc_slot
  import hazard_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] lat,
  input  logic [AW-1:0] dest_in,
  input  logic          retire,
  output logic          busy,
  output logic          ready,
  output logic [AW-1:0] dest
);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] dest_q, dest_d;

  // Load on issue, clear on retire, otherwise count down to 1.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dest_d = dest_q;
    if (load) begin
      busy_d = 1'b1;
      dest_d = dest_in;
      cnt_d  = (lat == '0) ? CW'(1) : lat;
    end else if (retire) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q && cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Slot state register; reset drops any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dest_q <= AW'(ZERO_REG);
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dest_q <= dest_d;
    end
  end

  assign busy  = busy_q;
  assign ready = busy_q && (cnt_q == CW'(1));
  assign dest  = dest_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand forwarding, stall/flush generation
// and a scoreboard of variable-latency mult/div ops.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int MC_SLOTS = 2,
  parameter int CW       = 4,
  localparam int SW = (MC_SLOTS > 1) ? $clog2(MC_SLOTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       rs_d,
  input  logic [AW-1:0]       rt_d,
  input  logic [AW-1:0]       write_reg_d,
  input  logic                reg_write_d,
  input  logic                branch_d,
  input  logic                mc_start_d,
  input  logic [AW-1:0]       rs_e,
  input  logic [AW-1:0]       rt_e,
  input  logic [AW-1:0]       write_reg_e,
  input  logic                reg_write_e,
  input  logic                mem_to_reg_e,
  input  logic                mc_start_e,
  input  logic [CW-1:0]       mc_lat_e,
  input  logic [AW-1:0]       write_reg_m,
  input  logic                reg_write_m,
  input  logic                mem_to_reg_m,
  input  logic [AW-1:0]       write_reg_w,
  input  logic                reg_write_w,
  output logic                forwardAD,
  output logic                forwardBD,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_e,
  output logic [MC_SLOTS-1:0] mc_busy,
  output logic                mc_wb_valid,
  output logic [AW-1:0]       mc_wb_reg,
  output logic [SW-1:0]       mc_wb_slot
);

  localparam logic [AW-1:0] RZ = AW'(ZERO_REG);

  logic [MC_SLOTS-1:0]         slot_busy;
  logic [MC_SLOTS-1:0]         slot_rdy;
  logic [MC_SLOTS-1:0][AW-1:0] slot_dest;
  logic [MC_SLOTS-1:0]         load;
  logic [MC_SLOTS-1:0]         retire;
  logic                        alloc_done;
  logic                        any_free;
  int unsigned                 nfree;
  logic pend_rs, pend_rt, pend_wd;
  logic lwstall, brstall, rawstall, wawstall, structstall;
  logic stall;

  function automatic logic [1:0] fwd_e(
    input logic [AW-1:0] src,
    input logic [AW-1:0] wm,
    input logic          rwm,
    input logic [AW-1:0] ww,
    input logic          rww
  );
    if (src != RZ && rwm && src == wm) return FWD_M;
    if (src != RZ && rww && src == ww) return FWD_W;
    return FWD_RF;
  endfunction

  assign forwardAE = fwd_e(rs_e, write_reg_m, reg_write_m,
                           write_reg_w, reg_write_w);
  assign forwardBE = fwd_e(rt_e, write_reg_m, reg_write_m,
                           write_reg_w, reg_write_w);

  assign forwardAD = rs_d != RZ && rs_d == write_reg_m
                     && reg_write_m;
  assign forwardBD = rt_d != RZ && rt_d == write_reg_m
                     && reg_write_m;

  genvar g;
  for (g = 0; g < MC_SLOTS; g++) begin : g_slot
    mc_slot #(.AW(AW), .CW(CW)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (load[g]),
      .lat     (mc_lat_e),
      .dest_in (write_reg_e),
      .retire  (retire[g]),
      .busy    (slot_busy[g]),
      .ready   (slot_rdy[g]),
      .dest    (slot_dest[g])
    );
  end

  assign mc_busy  = slot_busy;
  assign any_free = |(~slot_busy);

  // Issue into the lowest-index idle slot; a retiring slot is still busy.
  always_comb begin
    load       = '0;
    alloc_done = 1'b0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      if (!alloc_done && !slot_busy[i]) begin
        load[i]    = mc_start_e;
        alloc_done = 1'b1;
      end
    end
  end

  // Single write-back port: lowest-index ready slot wins.
  always_comb begin
    retire      = '0;
    mc_wb_valid = 1'b0;
    mc_wb_reg   = RZ;
    mc_wb_slot  = '0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      if (!mc_wb_valid && slot_rdy[i]) begin
        retire[i]   = 1'b1;
        mc_wb_valid = 1'b1;
        mc_wb_reg   = slot_dest[i];
        mc_wb_slot  = SW'(i);
      end
    end
  end

  // Registers owed by an in-flight or just-issuing op.
  always_comb begin
    pend_rs = mc_start_e && write_reg_e == rs_d;
    pend_rt = mc_start_e && write_reg_e == rt_d;
    pend_wd = mc_start_e && write_reg_e == write_reg_d;
    for (int i = 0; i < MC_SLOTS; i++) begin
      if (slot_busy[i]) begin
        if (slot_dest[i] == rs_d)        pend_rs = 1'b1;
        if (slot_dest[i] == rt_d)        pend_rt = 1'b1;
        if (slot_dest[i] == write_reg_d) pend_wd = 1'b1;
      end
    end
    pend_rs = pend_rs && rs_d != RZ;
    pend_rt = pend_rt && rt_d != RZ;
    pend_wd = pend_wd && write_reg_d != RZ;
  end

  // Idle slots, before the issuing op in E takes one.
  always_comb begin
    nfree = 0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      nfree = nfree + 32'(!slot_busy[i]);
    end
  end

  assign lwstall = mem_to_reg_e && write_reg_e != RZ
                   && (rs_d == write_reg_e
                   || rt_d == write_reg_e);

  assign brstall = branch_d && (
      (reg_write_e && write_reg_e != RZ
       && (rs_d == write_reg_e || rt_d == write_reg_e))
   || (mem_to_reg_m && write_reg_m != RZ
       && (rs_d == write_reg_m || rt_d == write_reg_m)));

  assign rawstall    = pend_rs || pend_rt;
  assign wawstall    = reg_write_d && pend_wd;
  assign structstall = mc_start_d
                       && (nfree <= 32'(mc_start_e));

  assign stall = lwstall | brstall | rawstall
               | wawstall | structstall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  a_issue_has_slot: assert property (
    @(posedge clk) disable iff (reset)
    mc_start_e |-> any_free);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed and
// random cycles checked against a due-time model.
module tb_hazard_scoreboard;

  logic       clk, reset;
  logic [4:0] rs_d, rt_d, write_reg_d;
  logic       reg_write_d, branch_d, mc_start_d;
  logic [4:0] rs_e, rt_e, write_reg_e;
  logic       reg_write_e, mem_to_reg_e, mc_start_e;
  logic [3:0] mc_lat_e;
  logic [4:0] write_reg_m;
  logic       reg_write_m, mem_to_reg_m;
  logic [4:0] write_reg_w;
  logic       reg_write_w;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       stall_f, stall_d, flush_e;
  logic [1:0] mc_busy;
  logic       mc_wb_valid;
  logic [4:0] mc_wb_reg;
  logic       mc_wb_slot;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .write_reg_d(write_reg_d),
    .reg_write_d(reg_write_d), .branch_d(branch_d),
    .mc_start_d(mc_start_d),
    .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mc_start_e(mc_start_e), .mc_lat_e(mc_lat_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid),
    .mc_wb_reg(mc_wb_reg), .mc_wb_slot(mc_wb_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs_d, rt_d, wr_d;
    logic       rw_d, br_d, mcs_d;
    logic [4:0] rs_e, rt_e, wr_e;
    logic       rw_e, m2r_e, mcs_e;
    logic [3:0] lat;
    logic [4:0] wr_m;
    logic       rw_m, m2r_m;
    logic [4:0] wr_w;
    logic       rw_w;
  } stim_t;

  typedef struct packed {
    logic       fad, fbd;
    logic [1:0] fae, fbe;
    logic       stall;
    logic [1:0] busy;
    logic       wbv;
    logic [4:0] wbr;
    logic       wbs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Model: each op is a destination plus the absolute
  // cycle from which it may write back.
  bit         op_v[2];
  logic [4:0] op_d[2];
  int         op_due[2];

  function automatic logic [1:0] fsel(logic [4:0] s, stim_t t);
    if (s != 0 && t.rw_m && s == t.wr_m) return 2'd2;
    if (s != 0 && t.rw_w && s == t.wr_w) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit pend(logic [4:0] r, stim_t t);
    if (r == 0) return 0;
    if (t.mcs_e && t.wr_e == r) return 1;
    for (int i = 0; i < 2; i++)
      if (op_v[i] && op_d[i] == r) return 1;
    return 0;
  endfunction

  function automatic int free_slots();
    int n = 0;
    for (int i = 0; i < 2; i++) if (!op_v[i]) n++;
    return n;
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    int   w, k;
    bit   lw, br, st;
    @(negedge clk);
    reset = s.rst;
    rs_d = s.rs_d; rt_d = s.rt_d; write_reg_d = s.wr_d;
    reg_write_d = s.rw_d; branch_d = s.br_d;
    mc_start_d = s.mcs_d;
    rs_e = s.rs_e; rt_e = s.rt_e; write_reg_e = s.wr_e;
    reg_write_e = s.rw_e; mem_to_reg_e = s.m2r_e;
    mc_start_e = s.mcs_e; mc_lat_e = s.lat;
    write_reg_m = s.wr_m; reg_write_m = s.rw_m;
    mem_to_reg_m = s.m2r_m;
    write_reg_w = s.wr_w; reg_write_w = s.rw_w;
    if (s.rst) begin
      op_v[0] = 0;
      op_v[1] = 0;
    end
    e = '0;
    e.fad = s.rs_d != 0 && s.rw_m && s.rs_d == s.wr_m;
    e.fbd = s.rt_d != 0 && s.rw_m && s.rt_d == s.wr_m;
    e.fae = fsel(s.rs_e, s);
    e.fbe = fsel(s.rt_e, s);
    e.busy = {op_v[1], op_v[0]};
    w = -1;
    for (int i = 0; i < 2; i++)
      if (w < 0 && op_v[i] && op_due[i] <= cyc) w = i;
    e.wbv = (w >= 0);
    e.wbr = (w >= 0) ? op_d[w] : 5'd0;
    e.wbs = (w == 1);
    lw = s.m2r_e && s.wr_e != 0
         && (s.rs_d == s.wr_e || s.rt_d == s.wr_e);
    br = s.br_d && (
         (s.rw_e && s.wr_e != 0
          && (s.rs_d == s.wr_e || s.rt_d == s.wr_e))
      || (s.m2r_m && s.wr_m != 0
          && (s.rs_d == s.wr_m || s.rt_d == s.wr_m)));
    st = s.mcs_d && (free_slots() - int'(s.mcs_e) <= 0);
    e.stall = lw || br || pend(s.rs_d, s) || pend(s.rt_d, s)
              || (s.rw_d && pend(s.wr_d, s)) || st;
    exp_q.push_back(e);
    if (!s.rst) begin
      k = -1;
      for (int i = 0; i < 2; i++)
        if (k < 0 && !op_v[i]) k = i;
      if (w >= 0) op_v[w] = 0;
      if (s.mcs_e && k >= 0) begin
        op_v[k]   = 1;
        op_d[k]   = s.wr_e;
        op_due[k] = cyc + ((s.lat == 0) ? 1 : int'(s.lat));
      end
    end
    cyc++;
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, x);
    end
  endtask

  // Monitor: outputs are valid every cycle, compared
  // mid-cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("forwardAD", 32'(forwardAD), 32'(e.fad));
        chk("forwardBD", 32'(forwardBD), 32'(e.fbd));
        chk("forwardAE", 32'(forwardAE), 32'(e.fae));
        chk("forwardBE", 32'(forwardBE), 32'(e.fbe));
        chk("stall_f", 32'(stall_f), 32'(e.stall));
        chk("stall_d", 32'(stall_d), 32'(e.stall));
        chk("flush_e", 32'(flush_e), 32'(e.stall));
        chk("mc_busy", 32'(mc_busy), 32'(e.busy));
        chk("mc_wb_valid", 32'(mc_wb_valid), 32'(e.wbv));
        chk("mc_wb_reg", 32'(mc_wb_reg), 32'(e.wbr));
        chk("mc_wb_slot", 32'(mc_wb_slot), 32'(e.wbs));
      end
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    s.rst   = ($urandom_range(0, 59) == 0);
    s.rs_d  = 5'($urandom_range(0, 7));
    s.rt_d  = 5'($urandom_range(0, 7));
    s.wr_d  = 5'($urandom_range(0, 7));
    s.rw_d  = 1'($urandom_range(0, 1));
    s.br_d  = ($urandom_range(0, 3) == 0);
    s.mcs_d = ($urandom_range(0, 2) == 0);
    s.rs_e  = 5'($urandom_range(0, 7));
    s.rt_e  = 5'($urandom_range(0, 7));
    s.wr_e  = 5'($urandom_range(0, 7));
    s.rw_e  = 1'($urandom_range(0, 1));
    s.m2r_e = ($urandom_range(0, 3) == 0);
    s.mcs_e = ($urandom_range(0, 2) == 0)
              && !s.rst && free_slots() > 0;
    s.lat   = ($urandom_range(0, 9) == 0)
              ? 4'd15 : 4'($urandom_range(0, 6));
    s.wr_m  = 5'($urandom_range(0, 7));
    s.rw_m  = 1'($urandom_range(0, 1));
    s.m2r_m = ($urandom_range(0, 3) == 0);
    s.wr_w  = 5'($urandom_range(0, 7));
    s.rw_w  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1;
    {rs_d, rt_d, write_reg_d, reg_write_d, branch_d} = '0;
    {mc_start_d, rs_e, rt_e, write_reg_e} = '0;
    {reg_write_e, mem_to_reg_e, mc_start_e, mc_lat_e} = '0;
    {write_reg_m, reg_write_m, mem_to_reg_m} = '0;
    {write_reg_w, reg_write_w} = '0;

    s = idle(); s.rst = 1;
    repeat (2) step(s);
    step(idle());

    s = idle();
    s.rs_e = 3; s.wr_m = 3; s.rw_m = 1;
    s.wr_w = 3; s.rw_w = 1;
    step(s);
    s.rs_e = 0; s.rt_e = 3; s.rw_m = 0;
    step(s);

    s = idle();
    s.m2r_e = 1; s.wr_e = 8; s.rw_e = 1; s.rt_d = 8;
    step(s);
    step(idle());

    s = idle();
    s.mcs_e = 1; s.wr_e = 9; s.lat = 4; s.rs_d = 9;
    step(s);
    s.mcs_e = 0; s.wr_e = 0;
    repeat (6) step(s);

    s = idle(); s.mcs_e = 1; s.wr_e = 5; s.lat = 3;
    step(s);
    s.wr_e = 6; s.lat = 2;
    step(s);
    repeat (4) step(idle());

    s = idle(); s.mcs_e = 1; s.wr_e = 10; s.lat = 6;
    step(s);
    s.wr_e = 11; s.lat = 6;
    step(s);
    s = idle(); s.mcs_d = 1;
    repeat (8) step(s);

    s = idle(); s.mcs_e = 1; s.wr_e = 12; s.lat = 5;
    step(s);
    step(idle());
    s = idle(); s.rst = 1;
    step(s);
    repeat (5) step(idle());

    s = idle(); s.mcs_e = 1; s.wr_e = 13; s.lat = 0;
    step(s);
    repeat (2) step(idle());

    repeat (3000) step(rnd());
    step(idle());

    repeat (3) @(negedge clk);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage pipeline.
- Keeps the existing register forwarding: E-stage operands from M/W, and D-stage branch-compare operands from M.
- Adds centralised stall/flush generation and a scoreboard of MC_SLOTS in-flight multi-cycle (mult/div) operations with variable latency and one shared register-file write-back port.
- Sits beside the datapath; drives its mux selects, stage enables and the multi-cycle write-back port.

Parameters:
- AW, 5, register address width (register 0 is hard-wired zero).
- MC_SLOTS, 2, maximum concurrent multi-cycle operations.
- CW, 4, latency counter width; maximum latency is 2^CW-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rs_d, rt_d  in  AW  D-stage source registers
- write_reg_d  in  AW  D-stage destination
- reg_write_d, branch_d, mc_start_d  in  1  D-stage decode flags
- rs_e, rt_e, write_reg_e  in  AW  E-stage sources and destination
- reg_write_e, mem_to_reg_e  in  1  E-stage flags
- mc_start_e  in  1  E-stage instruction issues a multi-cycle op this cycle
- mc_lat_e  in  CW  latency of the issuing op
- write_reg_m  in  AW  M-stage destination
- reg_write_m, mem_to_reg_m  in  1  M-stage flags
- write_reg_w  in  AW  W-stage destination
- reg_write_w  in  1  W-stage flag
- forwardAD, forwardBD  out  1  D-stage compare operand comes from the M-stage ALU result
- forwardAE, forwardBE  out  2  E-stage operand select: 00 register file, 01 W, 10 M, 11 reserved (never driven)
- stall_f, stall_d, flush_e  out  1  stage control
- mc_busy  out  MC_SLOTS  per-slot occupied flag
- mc_wb_valid  out  1  multi-cycle result writes the register file this cycle
- mc_wb_reg  out  AW  destination of that write
- mc_wb_slot  out  $clog2(MC_SLOTS)  slot being retired

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-high.
- Reset clears every slot (busy=0, count=0, dest=0), so mc_busy=0, mc_wb_valid=0, mc_wb_reg=0 and mc_wb_slot=0. Reset mid-operation discards all in-flight ops with no write-back.
- Forwarding (combinational, zero latency):
  - A source equal to 0 never forwards.
  - E stage: M match with reg_write_m gives 10; otherwise W match with reg_write_w gives 01; otherwise 00. M has priority over W.
  - D stage: forwardAD/forwardBD = source equals write_reg_m, reg_write_m set, source nonzero.
- Slot state: busy, dest[AW], count[CW].
  - Issue: on mc_start_e, the lowest-index slot that is not busy loads busy=1, dest=write_reg_e, count=max(mc_lat_e,1).
  - A slot retiring this cycle is not reusable until the next cycle.
  - mc_start_e with no free slot is a protocol violation (stall logic prevents it); assert in simulation; state unchanged.
- Countdown: each busy slot with count>1 decrements every cycle. A slot with count==1 is "ready".
- Retirement: the lowest-index ready slot drives mc_wb_valid=1, mc_wb_reg=dest, mc_wb_slot=index, and clears busy at the clock edge. Other ready slots hold count at 1 and retire in later cycles, one per cycle in index order.
- Timing: an op issued in cycle t with latency L writes back in cycle t+L when uncontended.
- Pending(r): some busy slot has dest==r and r!=0, OR mc_start_e is set with write_reg_e==r.
- Stall terms (all ignore register 0):
  - lwstall: mem_to_reg_e, and rs_d or rt_d equals write_reg_e.
  - brstall: branch_d, and either (reg_write_e and a source equals write_reg_e) or (mem_to_reg_m and a source equals write_reg_m).
  - rawstall: Pending(rs_d) or Pending(rt_d).
  - wawstall: reg_write_d and Pending(write_reg_d).
  - structstall: mc_start_d and no slot free after this edge. Count free slots ignoring retirements, plus mc_start_e consuming one.
- stall_f = stall_d = flush_e = OR of all stall terms. The consumer re-reads the register file the cycle after the retirement write.

Decomposition:
- Package hazard_pkg: forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; the zero-register constant.
- Sub-module mc_slot, instantiated MC_SLOTS times:
  - inputs: load, lat, dest_in, retire;
  - outputs: busy, ready, dest.
- Top level holds allocation, the retirement priority encoder, the stall OR-tree and forwarding.

Test Plan:
- rs_e=3, write_reg_m=3, reg_write_m=1, write_reg_w=3, reg_write_w=1 -> forwardAE=10; rs_e=0 with the same inputs -> forwardAE=00.
- mem_to_reg_e=1, write_reg_e=8, reg_write_e=1, rt_d=8 for one cycle -> stall_f=stall_d=flush_e=1 for exactly that cycle.
- mc_start_e at cycle t, write_reg_e=9, mc_lat_e=4, rs_d=9 held -> stall in cycles t..t+4; mc_wb_valid=1 with mc_wb_reg=9 in cycle t+4; stall=0 in cycle t+5.
- Slot0 issued at t with latency 3, slot1 issued at t+1 with latency 2 -> cycle t+3 retires slot0 (mc_wb_slot=0); cycle t+4 retires slot1 (mc_wb_slot=1); mc_wb_valid never covers both in one cycle.
- MC_SLOTS=2, both slots busy, mc_start_d=1 -> stall_d=1 until the cycle after the first retirement, then 0.
- Issue with latency 5, assert reset in cycle t+2 -> mc_busy=0 immediately; no mc_wb_valid in cycles t+2..t+6.
